// File: rtl/ibex_trace_pkg.sv
// Shared types for the RVFI trace capture controller: controller states and the
// four-word trace record layout.
package ibex_trace_pkg;

    localparam int TraceRecWords = 4;

    typedef enum logic [1:0] {
        TRACE_IDLE    = 2'd0,
        TRACE_ARMED   = 2'd1,
        TRACE_CAPTURE = 2'd2,
        TRACE_STOPPED = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic        trap;
        logic        intr;
        logic        ovf;
        logic [4:0]  rd_addr;
        logic [23:0] seq;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] wdata;
    } trace_rec_t;

    // Word idx of a record in emission order.
    function automatic logic [31:0] rec_word(trace_rec_t rec, logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = {rec.trap, rec.intr, rec.ovf, rec.rd_addr, rec.seq};
            2'd1:    w = rec.pc;
            2'd2:    w = rec.insn;
            default: w = rec.wdata;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ibex_trace_serializer.sv
// Holds one trace record and emits it as four 32-bit words over valid/ready;
// loads the next record in the same cycle the last word is accepted.
module ibex_trace_serializer
    import ibex_trace_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rec_valid_i,
    input  trace_rec_t  rec_i,
    output logic        rec_pop_o,
    output logic        trace_valid_o,
    output logic [31:0] trace_data_o,
    output logic        trace_last_o,
    input  logic        trace_ready_i
);

    trace_rec_t  rec_q, rec_d;
    logic        busy_q, busy_d;
    logic [1:0]  word_q, word_d;
    logic        accept;
    logic        free;

    always_comb begin
        accept    = busy_q && trace_ready_i;
        free      = !busy_q || (accept && (word_q == 2'(TraceRecWords - 1)));
        rec_pop_o = free && rec_valid_i;
        rec_d     = rec_q;
        busy_d    = busy_q;
        word_d    = word_q;
        if (accept) begin
            word_d = word_q + 2'd1;
        end
        if (free) begin
            busy_d = 1'b0;
        end
        if (rec_pop_o) begin
            rec_d  = rec_i;
            busy_d = 1'b1;
            word_d = 2'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rec_q  <= '0;
            busy_q <= 1'b0;
            word_q <= 2'd0;
        end else begin
            rec_q  <= rec_d;
            busy_q <= busy_d;
            word_q <= word_d;
        end
    end

    assign trace_valid_o = busy_q;
    assign trace_data_o  = busy_q ? rec_word(rec_q, word_q) : 32'h0;
    assign trace_last_o  = busy_q && (word_q == 2'(TraceRecWords - 1));

endmodule

// File: rtl/ibex_trace_capture_ctrl.sv
// Qualifies RVFI retirements (enable, PC trigger, stop count), buffers them in a
// small circular FIFO and streams each record through the serializer.
module ibex_trace_capture_ctrl
    import ibex_trace_pkg::*;
#(
    parameter int FifoDepth = 4,
    parameter int CntW      = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cfg_enable_i,
    input  logic            cfg_trig_en_i,
    input  logic [31:0]     cfg_trig_pc_i,
    input  logic [CntW-1:0] cfg_stop_count_i,
    input  logic            rvfi_valid,
    input  logic [31:0]     rvfi_pc_rdata,
    input  logic [31:0]     rvfi_insn,
    input  logic [4:0]      rvfi_rd_addr,
    input  logic [31:0]     rvfi_rd_wdata,
    input  logic            rvfi_trap,
    input  logic            rvfi_intr,
    output logic            trace_valid_o,
    output logic [31:0]     trace_data_o,
    output logic            trace_last_o,
    input  logic            trace_ready_i,
    output logic [1:0]      state_o,
    output logic [CntW-1:0] captured_count_o,
    output logic [CntW-1:0] dropped_count_o
);

    localparam int AW = $clog2(FifoDepth);

    trace_state_e    state_q, state_d;
    logic [CntW-1:0] cap_q, cap_d, drop_q, drop_d;
    logic            ovf_q, ovf_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    trace_rec_t      mem_q [FifoDepth];

    logic            fifo_empty, fifo_full;
    logic            capture, push_req, fifo_push, fifo_pop;
    logic            ser_valid, ser_pop;
    trace_rec_t      new_rec, ser_rec;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    always_comb begin
        new_rec         = '0;
        new_rec.trap    = rvfi_trap;
        new_rec.intr    = rvfi_intr;
        new_rec.ovf     = ovf_q;
        new_rec.rd_addr = rvfi_rd_addr;
        new_rec.seq     = cap_q[23:0];
        new_rec.pc      = rvfi_pc_rdata;
        new_rec.insn    = rvfi_insn;
        new_rec.wdata   = rvfi_rd_wdata;
    end

    always_comb begin
        state_d  = state_q;
        cap_d    = cap_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        capture  = 1'b0;
        case (state_q)
            TRACE_IDLE: begin
                if (cfg_enable_i) begin
                    cap_d   = '0;
                    drop_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = cfg_trig_en_i ? TRACE_ARMED : TRACE_CAPTURE;
                end
            end
            TRACE_ARMED: begin
                if (rvfi_valid && (rvfi_pc_rdata == cfg_trig_pc_i)) begin
                    capture = 1'b1;
                    state_d = TRACE_CAPTURE;
                end
            end
            TRACE_CAPTURE: capture = rvfi_valid;
            default: ;
        endcase

        // Fullness is judged before any same-cycle pop: a full FIFO always drops.
        push_req = capture && !fifo_full;
        if (capture && fifo_full) begin
            ovf_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + CntW'(1);
            end
        end
        if (push_req) begin
            ovf_d = 1'b0;
            if (cap_q != '1) begin
                cap_d = cap_q + CntW'(1);
            end
            if ((cfg_stop_count_i != '0) && (cap_d == cfg_stop_count_i)) begin
                state_d = TRACE_STOPPED;
            end
        end
        if ((state_q != TRACE_IDLE) && !cfg_enable_i) begin
            state_d = TRACE_IDLE;
        end
    end

    // An empty FIFO lets a fresh record go straight into a free serializer.
    assign ser_valid = !fifo_empty || push_req;
    assign ser_rec   = fifo_empty ? new_rec : mem_q[rd_ptr_q[AW-1:0]];
    assign fifo_pop  = ser_pop && !fifo_empty;
    assign fifo_push = push_req && !(ser_pop && fifo_empty);
    assign wr_ptr_d  = wr_ptr_q + (AW+1)'(fifo_push);
    assign rd_ptr_d  = rd_ptr_q + (AW+1)'(fifo_pop);

    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= new_rec;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= TRACE_IDLE;
            cap_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cap_q    <= cap_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    ibex_trace_serializer u_serializer (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .rec_valid_i   (ser_valid),
        .rec_i         (ser_rec),
        .rec_pop_o     (ser_pop),
        .trace_valid_o (trace_valid_o),
        .trace_data_o  (trace_data_o),
        .trace_last_o  (trace_last_o),
        .trace_ready_i (trace_ready_i)
    );

    assign state_o          = state_q;
    assign captured_count_o = cap_q;
    assign dropped_count_o  = drop_q;

endmodule

// File: tb/tb_ibex_trace_capture_ctrl.sv
// Directed and randomized checks of the trace capture controller against a
// queue-based behavioural model.
module tb_ibex_trace_capture_ctrl;

    localparam int Depth = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cfg_enable_i = 1'b0;
    logic        cfg_trig_en_i = 1'b0;
    logic [31:0] cfg_trig_pc_i = '0;
    logic [31:0] cfg_stop_count_i = '0;
    logic        rvfi_valid = 1'b0;
    logic [31:0] rvfi_pc_rdata = '0;
    logic [31:0] rvfi_insn = '0;
    logic [4:0]  rvfi_rd_addr = '0;
    logic [31:0] rvfi_rd_wdata = '0;
    logic        rvfi_trap = 1'b0;
    logic        rvfi_intr = 1'b0;
    logic        trace_valid_o;
    logic [31:0] trace_data_o;
    logic        trace_last_o;
    logic        trace_ready_i = 1'b1;
    logic [1:0]  state_o;
    logic [31:0] captured_count_o;
    logic [31:0] dropped_count_o;

    ibex_trace_capture_ctrl #(.FifoDepth(Depth), .CntW(32)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .cfg_enable_i     (cfg_enable_i),
        .cfg_trig_en_i    (cfg_trig_en_i),
        .cfg_trig_pc_i    (cfg_trig_pc_i),
        .cfg_stop_count_i (cfg_stop_count_i),
        .rvfi_valid       (rvfi_valid),
        .rvfi_pc_rdata    (rvfi_pc_rdata),
        .rvfi_insn        (rvfi_insn),
        .rvfi_rd_addr     (rvfi_rd_addr),
        .rvfi_rd_wdata    (rvfi_rd_wdata),
        .rvfi_trap        (rvfi_trap),
        .rvfi_intr        (rvfi_intr),
        .trace_valid_o    (trace_valid_o),
        .trace_data_o     (trace_data_o),
        .trace_last_o     (trace_last_o),
        .trace_ready_i    (trace_ready_i),
        .state_o          (state_o),
        .captured_count_o (captured_count_o),
        .dropped_count_o  (dropped_count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int words_seen = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pending records (FIFO) plus the record being emitted.
    int           m_state;
    logic [31:0]  m_cap, m_drop;
    bit           m_ovf;
    logic [127:0] m_pend[$];
    logic [127:0] m_cur;
    bit           m_act;
    int           m_word;

    function automatic logic [31:0] word_of(logic [127:0] r, int idx);
        return r[127 - 32*idx -: 32];
    endfunction

    task automatic model_reset();
        m_state = 0; m_cap = '0; m_drop = '0; m_ovf = 0;
        m_pend.delete(); m_cur = '0; m_act = 0; m_word = 0;
    endtask

    task automatic model_edge();
        bit full, cap_ev, acc, have_new;
        int nxt;
        logic [127:0] nrec;
        full = (m_pend.size() == Depth);
        acc = m_act && trace_ready_i;
        nxt = m_state; cap_ev = 0; have_new = 0; nrec = '0;
        case (m_state)
            0: if (cfg_enable_i) begin
                   m_cap = '0; m_drop = '0; m_ovf = 0;
                   nxt = cfg_trig_en_i ? 1 : 2;
               end
            1: if (rvfi_valid && rvfi_pc_rdata == cfg_trig_pc_i) begin cap_ev = 1; nxt = 2; end
            2: cap_ev = rvfi_valid;
            default: ;
        endcase
        if (cap_ev) begin
            if (full) begin
                if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
                m_ovf = 1;
            end else begin
                nrec = {rvfi_trap, rvfi_intr, m_ovf, rvfi_rd_addr, m_cap[23:0],
                        rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata};
                have_new = 1;
                m_ovf = 0;
                if (m_cap != 32'hFFFF_FFFF) m_cap = m_cap + 1;
                if (cfg_stop_count_i != 0 && m_cap == cfg_stop_count_i) nxt = 3;
            end
        end
        if (m_state != 0 && !cfg_enable_i) nxt = 0;
        m_state = nxt;
        if (acc) begin
            if (m_word == 3) m_act = 0;
            else m_word++;
        end
        if (!m_act) begin
            if (m_pend.size() > 0) begin
                m_cur = m_pend.pop_front(); m_act = 1; m_word = 0;
            end else if (have_new) begin
                m_cur = nrec; m_act = 1; m_word = 0; have_new = 0;
            end
        end
        if (have_new) m_pend.push_back(nrec);
    endtask

    task automatic compare_outputs();
        check_val("valid", trace_valid_o, m_act);
        check_val("data", trace_data_o, m_act ? word_of(m_cur, m_word) : 32'h0);
        check_val("last", trace_last_o, m_act && m_word == 3);
        check_val("state", state_o, m_state[1:0]);
        check_val("captured", captured_count_o, m_cap);
        check_val("dropped", dropped_count_o, m_drop);
    endtask

    task automatic step();
        @(posedge clk_i);
        if (!rst_ni) model_reset();
        else model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic retire(input logic [31:0] pc);
        rvfi_valid    = 1'b1;
        rvfi_pc_rdata = pc;
        rvfi_insn     = $urandom;
        rvfi_rd_addr  = 5'($urandom_range(0, 31));
        rvfi_rd_wdata = $urandom;
        rvfi_trap     = ($urandom_range(0, 7) == 0);
        rvfi_intr     = ($urandom_range(0, 7) == 0);
        step();
        rvfi_valid    = 1'b0;
    endtask

    task automatic go_idle();
        cfg_enable_i  = 1'b0;
        rvfi_valid    = 1'b0;
        trace_ready_i = 1'b1;
        repeat (30) step();
    endtask

    always @(posedge clk_i) begin
        if (rst_ni && trace_valid_o && trace_ready_i) begin
            words_seen++;
            if (trace_last_o)
                $display("[TB] record done @%0t wdata=%08h", $time, trace_data_o);
        end
    end

    initial begin
        int base;
        model_reset();
        repeat (2) step();
        check_val("rst_state", state_o, 0);
        check_val("rst_valid", trace_valid_o, 0);
        rst_ni = 1'b1;

        // Plain capture, three records back to back.
        cfg_enable_i = 1'b1;
        step();
        base = words_seen;
        retire(32'h1000); retire(32'h1004); retire(32'h1008);
        repeat (16) step();
        check_val("t1_words", 32'(words_seen - base), 12);
        check_val("t1_cap", captured_count_o, 3);
        check_val("t1_state", state_o, 2);

        // PC trigger.
        go_idle();
        cfg_trig_en_i = 1'b1;
        cfg_trig_pc_i = 32'h100;
        cfg_enable_i  = 1'b1;
        step();
        retire(32'hF8); retire(32'hFC);
        check_val("t2_armed", state_o, 1);
        retire(32'h100);
        check_val("t2_trig", state_o, 2);
        retire(32'h104);
        repeat (12) step();
        check_val("t2_cap", captured_count_o, 2);

        // Stop count.
        go_idle();
        cfg_trig_en_i    = 1'b0;
        cfg_stop_count_i = 32'd2;
        cfg_enable_i     = 1'b1;
        step();
        base = words_seen;
        repeat (5) retire(32'($urandom_range(0, 255) * 4));
        repeat (20) step();
        check_val("t3_cap", captured_count_o, 2);
        check_val("t3_state", state_o, 3);
        check_val("t3_words", 32'(words_seen - base), 8);

        // Overflow with a stalled sink.
        go_idle();
        cfg_stop_count_i = '0;
        cfg_enable_i     = 1'b1;
        step();
        trace_ready_i = 1'b0;
        base = words_seen;
        repeat (7) retire(32'h2000);
        check_val("t4_cap", captured_count_o, 5);
        check_val("t4_drop", dropped_count_o, 2);
        trace_ready_i = 1'b1;
        repeat (30) step();
        check_val("t4_words", 32'(words_seen - base), 20);
        retire(32'h3000);
        check_val("t4_ovf1", 32'(trace_data_o[29]), 1);
        repeat (4) step();
        retire(32'h3004);
        check_val("t4_ovf0", 32'(trace_data_o[29]), 0);
        repeat (4) step();

        // Stall pattern inside a record.
        retire(32'h4000);
        trace_ready_i = 1'b1; step();
        trace_ready_i = 1'b0; step();
        trace_ready_i = 1'b0; step();
        trace_ready_i = 1'b1; repeat (4) step();

        // Reset mid-record.
        trace_ready_i = 1'b0;
        retire(32'h5000);
        step();
        #2 rst_ni = 1'b0;
        #1;
        check_val("t6_valid", trace_valid_o, 0);
        check_val("t6_cap", captured_count_o, 0);
        check_val("t6_state", state_o, 0);
        model_reset();
        step();
        rst_ni = 1'b1;
        cfg_enable_i  = 1'b0;
        trace_ready_i = 1'b1;
        step();
        cfg_enable_i = 1'b1;
        step();
        retire(32'h6000);
        check_val("t6_seq0", {8'h0, trace_data_o[23:0]}, 0);
        repeat (8) step();

        // Randomized traffic with reconfiguration.
        for (int c = 0; c < 1500; c++) begin
            if (c % 250 == 0) begin
                cfg_enable_i  = 1'b0;
                rvfi_valid    = 1'b0;
                trace_ready_i = 1'b1;
                repeat (3) step();
                cfg_trig_en_i    = 1'($urandom_range(0, 1));
                cfg_trig_pc_i    = 32'(32'h100 + 4 * $urandom_range(0, 7));
                cfg_stop_count_i = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
                cfg_enable_i     = 1'b1;
            end
            rvfi_valid    = 1'($urandom_range(0, 1));
            rvfi_pc_rdata = 32'(32'h100 + 4 * $urandom_range(0, 7));
            rvfi_insn     = $urandom;
            rvfi_rd_addr  = 5'($urandom_range(0, 31));
            rvfi_rd_wdata = $urandom;
            rvfi_trap     = ($urandom_range(0, 7) == 0);
            rvfi_intr     = ($urandom_range(0, 7) == 0);
            trace_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) cfg_enable_i = ~cfg_enable_i;
            step();
        end
        go_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
